// File: rtl/color_class_det.sv
// ============================================================================
// color_class_det
// ----------------------------------------------------------------------------
// Classifies each video frame by its dominant colour. Every valid HSV pixel
// in a frame is binned into an achromatic class (0) or one of NUM_HUE_BINS
// hue classes (1..NUM_HUE_BINS). At the next frame sync the bin counters are
// scanned. The winning class is reported with a one-cycle pulse. If the
// winning count is below MIN_PIXELS, the report is 7 (NONE).
//
// Optional feature macro: COLOR_CLASS_DET_STATS_EN
//   defined   : frame_pix_o reports the per-frame pixel total, and drop_o
//               tracks ignored pixels and ignored frame syncs.
//   undefined : frame_pix_o and drop_o are tied to zero.
//
// Ports
//   sys_clk        in   rising-edge clock
//   sys_rst        in   synchronous active-high reset
//   hsv_h          in   [8:0] hue in degrees (values above 359 clamp to 359)
//   hsv_s          in   [8:0] saturation
//   hsv_v          in   [7:0] value
//   hsv_hs         in   line sync (registered only)
//   hsv_vs         in   frame sync; its rising edge closes a frame
//   hsv_de         in   pixel valid
//   color_o        out  [2:0] frame class code (0 achromatic, 1..N hue, 7 none)
//   color_valid_o  out  one-cycle pulse when color_o updates
//   max_count_o    out  [CNT_WIDTH-1:0] count of the winning class
//   frame_pix_o    out  [CNT_WIDTH-1:0] pixels counted in the reported frame
//   drop_o         out  sticky flag: a pixel or frame sync was ignored
// ============================================================================
module color_class_det #(
    parameter int NUM_HUE_BINS  = 6,
    parameter int HUE_BIN_WIDTH = 60,
    parameter int HUE_OFFSET    = 30,
    parameter int S_MIN         = 64,
    parameter int V_MIN         = 40,
    parameter int CNT_WIDTH     = 24,
    parameter int MIN_PIXELS    = 1024
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [8:0]           hsv_h,
    input  logic [8:0]           hsv_s,
    input  logic [7:0]           hsv_v,
    input  logic                 hsv_hs,
    input  logic                 hsv_vs,
    input  logic                 hsv_de,
    output logic [2:0]           color_o,
    output logic                 color_valid_o,
    output logic [CNT_WIDTH-1:0] max_count_o,
    output logic [CNT_WIDTH-1:0] frame_pix_o,
    output logic                 drop_o
);

    localparam int                   NUM_CLASSES = NUM_HUE_BINS + 1;
    localparam logic [2:0]           CLASS_NONE  = 3'd7;
    localparam logic [2:0]           LAST_CLASS  = 3'(NUM_HUE_BINS);
    localparam logic [9:0]           OFFSET_MOD  = 10'(HUE_OFFSET % 360);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_SCAN,
        ST_REPORT
    } state_t;

    state_t               state;
    logic                 vs_q;
    logic                 hs_q;
    logic                 vs_rise;
    logic                 drain_cnt;
    logic [2:0]           scan_idx;
    logic [2:0]           best_cls;
    logic [CNT_WIDTH-1:0] best_cnt;
    logic                 scan_last;

    logic [8:0]           h_clamped;
    logic [9:0]           h_sum;
    logic [9:0]           hh;
    logic [2:0]           hue_bin;
    logic                 achromatic;
    logic [2:0]           pix_class;

    logic                 s1_valid;
    logic [2:0]           s1_class;
    logic [CNT_WIDTH-1:0] bin_cnt [NUM_CLASSES];

    logic [CNT_WIDTH-1:0] scan_cnt;
    logic                 scan_better;
    logic [CNT_WIDTH-1:0] new_best_cnt;
    logic [2:0]           new_best_cls;
    logic                 below_min;

    assign vs_rise   = hsv_vs & ~vs_q;
    assign scan_last = (state == ST_SCAN) && (scan_idx == LAST_CLASS);

    // Pixel classification. The hue is rotated by HUE_OFFSET so that reds on
    // both sides of 0 degrees fall in the same bin. The bin index then comes
    // from a chain of threshold compares. The thresholds rise monotonically,
    // so the last one passed is floor(hh / width). Clamping to the top bin is
    // automatic because no threshold exists above it.
    always_comb begin
        h_clamped = (hsv_h > 9'd359) ? 9'd359 : hsv_h;
        h_sum     = {1'b0, h_clamped} + OFFSET_MOD;
        hh        = (h_sum >= 10'd360) ? (h_sum - 10'd360) : h_sum;
        hue_bin   = 3'd0;
        for (int k = 1; k < NUM_HUE_BINS; k++) begin
            if (int'(hh) >= k * HUE_BIN_WIDTH) begin
                hue_bin = 3'(k);
            end
        end
        achromatic = (hsv_s < 9'(S_MIN)) || (hsv_v < 8'(V_MIN));
        pix_class  = achromatic ? 3'd0 : (hue_bin + 3'd1);
    end

    // Stage 1: register the class of each pixel accepted during ACCUM.
    // Pixels arriving in any other state never enter the pipeline.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s1_class <= 3'd0;
        end else begin
            s1_valid <= hsv_de && (state == ST_ACCUM);
            s1_class <= pix_class;
        end
    end

    // Stage 2: saturating increment of the counter for the registered class.
    // REPORT clears every counter so the next frame starts from zero.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || (state == ST_REPORT)) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bin_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (s1_valid && (s1_class == 3'(i)) && (bin_cnt[i] != CNT_MAX)) begin
                    bin_cnt[i] <= bin_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Running maximum for SCAN. The compare is strict, so on equal counts
    // the class visited first (the lowest index) keeps the lead.
    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == 3'(i)) begin
                scan_cnt = bin_cnt[i];
            end
        end
        scan_better  = (scan_idx == 3'd0) || (scan_cnt > best_cnt);
        new_best_cnt = scan_better ? scan_cnt : best_cnt;
        new_best_cls = scan_better ? scan_idx : best_cls;
        below_min    = 64'(new_best_cnt) < 64'(MIN_PIXELS);
    end

    // Frame control FSM. The outputs are loaded on the edge that enters
    // REPORT, so color_valid_o is high exactly during the REPORT cycle. The
    // latency from the detected vsync rise is 2 DRAIN cycles, plus
    // NUM_HUE_BINS+1 SCAN cycles, plus 1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            drain_cnt     <= 1'b0;
            scan_idx      <= 3'd0;
            best_cnt      <= '0;
            best_cls      <= 3'd0;
            color_o       <= CLASS_NONE;
            color_valid_o <= 1'b0;
            max_count_o   <= '0;
        end else begin
            vs_q          <= hsv_vs;
            hs_q          <= hsv_hs;
            color_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vs_rise) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (vs_rise) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state    <= ST_SCAN;
                        scan_idx <= 3'd0;
                    end
                end
                ST_SCAN: begin
                    best_cnt <= new_best_cnt;
                    best_cls <= new_best_cls;
                    scan_idx <= scan_idx + 3'd1;
                    if (scan_last) begin
                        state         <= ST_REPORT;
                        color_o       <= below_min ? CLASS_NONE : new_best_cls;
                        max_count_o   <= new_best_cnt;
                        color_valid_o <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    state <= ST_ACCUM;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COLOR_CLASS_DET_STATS_EN
    logic [CNT_WIDTH-1:0] pix_total;
    logic                 drop_frame;
    logic                 busy;
    logic                 drop_evt;

    assign busy     = (state == ST_DRAIN) || (state == ST_SCAN) || (state == ST_REPORT);
    assign drop_evt = busy && (hsv_de || vs_rise);

    // Frame statistics. pix_total follows the counted pixels. The drop flag
    // is sticky. REPORT clears it only when the frame that just closed had
    // no ignored input during DRAIN or SCAN.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_total   <= '0;
            frame_pix_o <= '0;
            drop_o      <= 1'b0;
            drop_frame  <= 1'b0;
        end else begin
            if (state == ST_REPORT) begin
                pix_total <= '0;
            end else if (s1_valid && (pix_total != CNT_MAX)) begin
                pix_total <= pix_total + CNT_ONE;
            end

            if (scan_last) begin
                frame_pix_o <= pix_total;
            end

            if (state == ST_REPORT) begin
                drop_o     <= drop_frame | drop_evt;
                drop_frame <= 1'b0;
            end else if (drop_evt) begin
                drop_o     <= 1'b1;
                drop_frame <= 1'b1;
            end
        end
    end
`else
    assign frame_pix_o = '0;
    assign drop_o      = 1'b0;
`endif

endmodule

// File: tb/tb_color_class_det.sv
// ============================================================================
// tb_color_class_det
// ----------------------------------------------------------------------------
// Self-checking bench for color_class_det. A default instance and a
// CNT_WIDTH=4 instance share every input. Expected results come from a
// per-class pixel tally kept in the bench. The tally is reduced with plain
// arithmetic: modulo binning, saturating min, and a first-wins maximum.
// ============================================================================
module tb_color_class_det;

    logic        sys_clk;
    logic        sys_rst;
    logic [8:0]  hsv_h;
    logic [8:0]  hsv_s;
    logic [7:0]  hsv_v;
    logic        hsv_hs;
    logic        hsv_vs;
    logic        hsv_de;

    logic [2:0]  color_o;
    logic        color_valid_o;
    logic [23:0] max_count_o;
    logic [23:0] frame_pix_o;
    logic        drop_o;

    logic [2:0]  sat_color_o;
    logic        sat_color_valid_o;
    logic [3:0]  sat_max_count_o;
    logic [3:0]  sat_frame_pix_o;
    logic        sat_drop_o;

    int errors = 0;
    int checks = 0;

    int exp_cnt [7];
    int exp_color;
    int exp_max;
    int exp_pix;
    int exp_sat_max;

    color_class_det dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .hsv_h         (hsv_h),
        .hsv_s         (hsv_s),
        .hsv_v         (hsv_v),
        .hsv_hs        (hsv_hs),
        .hsv_vs        (hsv_vs),
        .hsv_de        (hsv_de),
        .color_o       (color_o),
        .color_valid_o (color_valid_o),
        .max_count_o   (max_count_o),
        .frame_pix_o   (frame_pix_o),
        .drop_o        (drop_o)
    );

    color_class_det #(.CNT_WIDTH(4)) dut_sat (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .hsv_h         (hsv_h),
        .hsv_s         (hsv_s),
        .hsv_v         (hsv_v),
        .hsv_hs        (hsv_hs),
        .hsv_vs        (hsv_vs),
        .hsv_de        (hsv_de),
        .color_o       (sat_color_o),
        .color_valid_o (sat_color_valid_o),
        .max_count_o   (sat_max_count_o),
        .frame_pix_o   (sat_frame_pix_o),
        .drop_o        (sat_drop_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Class of a pixel under the default parameters.
    function automatic int model_class(input int h, input int s, input int v);
        int hc;
        int hh;
        int b;
        if (s < 64 || v < 40) return 0;
        hc = (h > 359) ? 359 : h;
        hh = (hc + 30) % 360;
        b  = hh / 60;
        if (b > 5) b = 5;
        return b + 1;
    endfunction

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one pixel cycle and tally it in the model if it is valid.
    task automatic put_pixel(input int h, input int s, input int v, input bit de);
        tick();
        hsv_h  = 9'(h);
        hsv_s  = 9'(s);
        hsv_v  = 8'(v);
        hsv_de = de;
        hsv_vs = 1'b0;
        hsv_hs = 1'($urandom_range(0, 1));
        if (de) exp_cnt[model_class(h, s, v)]++;
    endtask

    // Reduce the model tally to expected outputs, then clear it for the next frame.
    task automatic compute_expect();
        int best;
        int sbest;
        int sc [7];
        best  = 0;
        sbest = 0;
        exp_pix = 0;
        for (int c = 0; c < 7; c++) begin
            sc[c] = (exp_cnt[c] > 15) ? 15 : exp_cnt[c];
            exp_pix += exp_cnt[c];
        end
        for (int c = 1; c < 7; c++) begin
            if (exp_cnt[c] > exp_cnt[best]) best = c;
            if (sc[c] > sc[sbest]) sbest = c;
        end
        exp_max     = exp_cnt[best];
        exp_color   = (exp_max < 1024) ? 7 : best;
        exp_sat_max = sc[sbest];
        for (int c = 0; c < 7; c++) exp_cnt[c] = 0;
    endtask

    // Raise vsync for one cycle, optionally with a final pixel in the same
    // cycle. Then wait a bounded number of cycles for the report pulse.
    // lat is the cycle offset of the pulse, or -1 if no pulse arrived.
    // de_k, vs_k and rst_k inject a pixel, a vsync pulse or a reset at
    // that cycle offset.
    task automatic end_frame(input bit last_pix, input int lh, input int ls, input int lv,
                             input int de_k, input int vs_k, input int rst_k,
                             output int lat);
        tick();
        hsv_h  = 9'(lh);
        hsv_s  = 9'(ls);
        hsv_v  = 8'(lv);
        hsv_de = last_pix;
        hsv_vs = 1'b1;
        if (last_pix) exp_cnt[model_class(lh, ls, lv)]++;
        compute_expect();
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (color_valid_o) begin
                lat = k;
                hsv_de  = 1'b0;
                hsv_vs  = 1'b0;
                sys_rst = 1'b0;
                break;
            end
            hsv_h   = 9'd0;
            hsv_s   = 9'd200;
            hsv_v   = 8'd200;
            hsv_de  = (k == de_k);
            hsv_vs  = (k == vs_k);
            sys_rst = (k == rst_k);
        end
        hsv_de  = 1'b0;
        hsv_vs  = 1'b0;
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        hsv_h = '0; hsv_s = '0; hsv_v = '0; hsv_hs = 1'b0; hsv_vs = 1'b0; hsv_de = 1'b0;
        for (int c = 0; c < 7; c++) exp_cnt[c] = 0;
        repeat (3) tick();
        checks++; if (color_o !== 3'd7) begin errors++; $display("[TB] FAIL reset_color: got %0d expected 7", color_o); end
        checks++; if (color_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d expected 0", color_valid_o); end
        checks++; if (max_count_o !== 24'd0) begin errors++; $display("[TB] FAIL reset_max: got %0d expected 0", max_count_o); end
        checks++; if (frame_pix_o !== 24'd0) begin errors++; $display("[TB] FAIL reset_frame_pix: got %0d expected 0", frame_pix_o); end
        checks++; if (drop_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_o); end
        sys_rst = 1'b0;
    endtask

    task automatic test_single_red();
        int lat;
        end_frame(1'b0, 0, 0, 0, 0, 0, 0, lat);
        checks++; if (lat !== -1) begin errors++; $display("[TB] FAIL first_frame_no_report: got lat %0d expected -1", lat); end
        for (int i = 0; i < 1999; i++) put_pixel(0, 200, 200, 1'b1);
        end_frame(1'b1, 0, 200, 200, 0, 0, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL red_latency: got %0d expected 10", lat); end
        checks++; if (color_o !== 3'd1) begin errors++; $display("[TB] FAIL red_color: got %0d expected 1", color_o); end
        checks++; if (max_count_o !== 24'd2000) begin errors++; $display("[TB] FAIL red_max: got %0d expected 2000", max_count_o); end
`ifdef COLOR_CLASS_DET_STATS_EN
        checks++; if (frame_pix_o !== 24'd2000) begin errors++; $display("[TB] FAIL red_frame_pix: got %0d expected 2000", frame_pix_o); end
`else
        checks++; if (frame_pix_o !== 24'd0) begin errors++; $display("[TB] FAIL red_frame_pix: got %0d expected 0", frame_pix_o); end
`endif
        put_pixel(0, 0, 0, 1'b0);
        checks++; if (color_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL red_pulse_width: got %0d expected 0", color_valid_o); end
        checks++; if (color_o !== 3'd1) begin errors++; $display("[TB] FAIL red_color_hold: got %0d expected 1", color_o); end
    endtask

    task automatic test_tie();
        int lat;
        for (int i = 0; i < 1500; i++) put_pixel(120, 200, 200, 1'b1);
        for (int i = 0; i < 1499; i++) put_pixel(240, 200, 200, 1'b1);
        end_frame(1'b1, 240, 200, 200, 0, 0, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL tie_latency: got %0d expected 10", lat); end
        checks++; if (color_o !== 3'd3) begin errors++; $display("[TB] FAIL tie_color: got %0d expected 3", color_o); end
        checks++; if (max_count_o !== 24'd1500) begin errors++; $display("[TB] FAIL tie_max: got %0d expected 1500", max_count_o); end
    endtask

    task automatic test_below_min();
        int lat;
        for (int i = 0; i < 500; i++) begin
            put_pixel(180, 200, 200, 1'b1);
            if (i % 3 == 0) put_pixel(0, 200, 200, 1'b0);
        end
        end_frame(1'b0, 0, 0, 0, 0, 0, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL below_min_latency: got %0d expected 10", lat); end
        checks++; if (color_o !== 3'd7) begin errors++; $display("[TB] FAIL below_min_color: got %0d expected 7", color_o); end
        checks++; if (max_count_o !== 24'd500) begin errors++; $display("[TB] FAIL below_min_max: got %0d expected 500", max_count_o); end
    endtask

    task automatic test_achromatic_drop();
        int lat;
        for (int i = 0; i < 3000; i++) put_pixel($urandom_range(0, 359), 10, 200, 1'b1);
        end_frame(1'b0, 0, 0, 0, 6, 5, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL achrom_latency: got %0d expected 10", lat); end
        checks++; if (color_o !== 3'd0) begin errors++; $display("[TB] FAIL achrom_color: got %0d expected 0", color_o); end
        checks++; if (max_count_o !== 24'd3000) begin errors++; $display("[TB] FAIL achrom_max: got %0d expected 3000", max_count_o); end
        put_pixel(0, 0, 0, 1'b0);
`ifdef COLOR_CLASS_DET_STATS_EN
        checks++; if (drop_o !== 1'b1) begin errors++; $display("[TB] FAIL achrom_drop: got %0d expected 1", drop_o); end
`else
        checks++; if (drop_o !== 1'b0) begin errors++; $display("[TB] FAIL achrom_drop: got %0d expected 0", drop_o); end
`endif
    endtask

    task automatic test_saturate();
        int lat;
        for (int i = 0; i < 19; i++) put_pixel(60, 200, 200, 1'b1);
        end_frame(1'b1, 60, 200, 200, 0, 0, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 10", lat); end
        checks++; if (sat_max_count_o !== 4'd15) begin errors++; $display("[TB] FAIL sat_max: got %0d expected 15", sat_max_count_o); end
        checks++; if (sat_color_o !== 3'd7) begin errors++; $display("[TB] FAIL sat_color: got %0d expected 7", sat_color_o); end
        checks++; if (max_count_o !== 24'd20) begin errors++; $display("[TB] FAIL wide_max: got %0d expected 20", max_count_o); end
`ifdef COLOR_CLASS_DET_STATS_EN
        checks++; if (sat_frame_pix_o !== 4'd15) begin errors++; $display("[TB] FAIL sat_frame_pix: got %0d expected 15", sat_frame_pix_o); end
`endif
        put_pixel(0, 0, 0, 1'b0);
        checks++; if (drop_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_cleared: got %0d expected 0", drop_o); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        for (int i = 0; i < 1199; i++) put_pixel(300, 200, 200, 1'b1);
        end_frame(1'b1, 300, 200, 200, 0, 0, 5, lat);
        checks++; if (lat !== -1) begin errors++; $display("[TB] FAIL midscan_no_pulse: got lat %0d expected -1", lat); end
        checks++; if (color_o !== 3'd7) begin errors++; $display("[TB] FAIL midscan_color: got %0d expected 7", color_o); end
        checks++; if (max_count_o !== 24'd0) begin errors++; $display("[TB] FAIL midscan_max: got %0d expected 0", max_count_o); end
        for (int i = 0; i < 100; i++) put_pixel(300, 200, 200, 1'b1);
        end_frame(1'b0, 0, 0, 0, 0, 0, 0, lat);
        checks++; if (lat !== -1) begin errors++; $display("[TB] FAIL after_reset_no_report: got lat %0d expected -1", lat); end
        for (int i = 0; i < 1100; i++) put_pixel(300, 200, 200, 1'b1);
        end_frame(1'b0, 0, 0, 0, 0, 0, 0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL after_reset_latency: got %0d expected 10", lat); end
        checks++; if (color_o !== 3'd6) begin errors++; $display("[TB] FAIL after_reset_color: got %0d expected 6", color_o); end
        checks++; if (max_count_o !== 24'd1100) begin errors++; $display("[TB] FAIL after_reset_max: got %0d expected 1100", max_count_o); end
    endtask

    task automatic test_random();
        int lat;
        int n;
        int fav;
        int h;
        int edges [16] = '{0, 29, 30, 89, 90, 149, 150, 209, 210, 269, 270, 329, 330, 359, 360, 511};
        for (int f = 0; f < 5; f++) begin
            n   = $urandom_range(300, 2200);
            fav = $urandom_range(0, 511);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       h = edges[$urandom_range(0, 15)];
                    1:       h = $urandom_range(0, 511);
                    default: h = fav;
                endcase
                put_pixel(h, $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 3) != 0);
            end
            end_frame(1'b1, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 255), 0, 0, 0, lat);
            checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 10", f, lat); end
            checks++; if (color_o !== 3'(exp_color)) begin errors++; $display("[TB] FAIL rand%0d_color: got %0d expected %0d", f, color_o, exp_color); end
            checks++; if (max_count_o !== 24'(exp_max)) begin errors++; $display("[TB] FAIL rand%0d_max: got %0d expected %0d", f, max_count_o, exp_max); end
            checks++; if (sat_max_count_o !== 4'(exp_sat_max)) begin errors++; $display("[TB] FAIL rand%0d_sat_max: got %0d expected %0d", f, sat_max_count_o, exp_sat_max); end
`ifdef COLOR_CLASS_DET_STATS_EN
            checks++; if (frame_pix_o !== 24'(exp_pix)) begin errors++; $display("[TB] FAIL rand%0d_frame_pix: got %0d expected %0d", f, frame_pix_o, exp_pix); end
`else
            checks++; if (frame_pix_o !== 24'd0) begin errors++; $display("[TB] FAIL rand%0d_frame_pix: got %0d expected 0", f, frame_pix_o); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_red();
        test_tie();
        test_below_min();
        test_achromatic_drop();
        test_saturate();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_class_det.md
COLOR_CLASS_DET -- requirements
Module: color_class_det

Interface
REQ-001 SHALL have parameter NUM_HUE_BINS, default 6, number of chromatic classes, legal range 1..6.
REQ-002 SHALL have parameter HUE_BIN_WIDTH, default 60, width of each hue bin in degrees.
REQ-003 SHALL have parameter HUE_OFFSET, default 30, degrees added to hue modulo 360 before binning, so red around 0 lands in one bin.
REQ-004 SHALL have parameter S_MIN, default 64, 9-bit saturation threshold; below it a pixel is achromatic.
REQ-005 SHALL have parameter V_MIN, default 40, 8-bit value threshold; below it a pixel is achromatic.
REQ-006 SHALL have parameter CNT_WIDTH, default 24, bit width of each bin counter.
REQ-007 SHALL have parameter MIN_PIXELS, default 1024, minimum winning count for a valid class.
REQ-008 Port sys_clk, input, 1 bit: single clock. All logic is on the rising edge.
REQ-009 Port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-010 Port hsv_h, input, 9 bits: hue in degrees, 0..359.
REQ-011 Port hsv_s, input, 9 bits: saturation.
REQ-012 Port hsv_v, input, 8 bits: value.
REQ-013 Ports hsv_hs and hsv_vs, inputs, 1 bit each: line sync and frame sync.
REQ-014 Port hsv_de, input, 1 bit: pixel valid.
REQ-015 Port color_o, output, 3 bits: frame class code.
REQ-016 Port color_valid_o, output, 1 bit: one-cycle pulse when color_o updates.
REQ-017 Port max_count_o, output, CNT_WIDTH bits: count of the winning bin.
REQ-018 Port frame_pix_o, output, CNT_WIDTH bits: total counted pixels in the frame.
REQ-019 Port drop_o, output, 1 bit: sticky flag; at least one pixel was ignored.

Function
REQ-020 Class codes SHALL be:
- 0 = achromatic (hsv_s < S_MIN or hsv_v < V_MIN).
- 1..NUM_HUE_BINS = chromatic bin index + 1.
- 7 = NONE.
REQ-021 Pixels with hsv_h > 359 SHALL be treated as 359.
REQ-022 hh = (h + HUE_OFFSET) mod 360; bin = floor(hh / HUE_BIN_WIDTH), clamped to NUM_HUE_BINS-1. Binning SHALL use a comparator chain, not a divider.
REQ-023 The pixel path SHALL be 2 stages: stage 1 registers the class, stage 2 increments that class counter.
REQ-024 Bin counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 Frame boundary SHALL be the rising edge of hsv_vs, detected against a registered copy of hsv_vs.
REQ-026 FSM states and transitions SHALL be:
- IDLE: on first vsync rise, go to ACCUM.
- ACCUM: counts every hsv_de pixel; on vsync rise, go to DRAIN.
- DRAIN: 2 cycles, flushes the pipeline; then go to SCAN.
- SCAN: visits one counter per cycle, classes 0..NUM_HUE_BINS; then go to REPORT.
- REPORT: 1 cycle; go to ACCUM with all counters cleared in that same cycle.
REQ-027 A pixel in the final ACCUM cycle before the vsync rise SHALL be counted.
REQ-028 SCAN SHALL keep a strict-greater maximum, so on equal counts the lowest class index wins.
REQ-029 In REPORT:
- color_o = winning class, or 7 if the winning count < MIN_PIXELS.
- max_count_o = winning count.
- color_valid_o = 1 for exactly one cycle.
REQ-030 color_valid_o SHALL fire exactly NUM_HUE_BINS+4 cycles after the cycle in which the vsync rise is detected.
REQ-031 hsv_de asserted during DRAIN, SCAN or REPORT SHALL be ignored and SHALL set drop_o.
REQ-032 A vsync rise during DRAIN, SCAN or REPORT SHALL be ignored and SHALL set drop_o.
REQ-033 color_o and max_count_o SHALL hold their values between REPORT cycles.
REQ-034 hsv_hs SHALL be registered only; it has no effect on counting.

Reset
REQ-035 On sys_rst = 1 at a clock edge, the block SHALL take these values, also mid-frame and mid-SCAN:
- FSM = IDLE.
- All counters = 0.
- color_o = 7.
- color_valid_o = 0.
- max_count_o = 0.
- frame_pix_o = 0.
- drop_o = 0.
- Pipeline valids = 0.
- vsync register = 0.
REQ-036 The first frame after reset SHALL NOT produce a report; reporting starts at the second vsync rise.

Configuration
REQ-037 Macro COLOR_CLASS_DET_STATS_EN:
- Defined: frame_pix_o counts (saturating) every counted pixel in ACCUM and updates in REPORT.
- Defined: drop_o clears in REPORT only if no drop occurred during that frame's DRAIN/SCAN.
- Undefined: frame_pix_o = 0 and drop_o = 0 constantly, with their logic removed.
- All other behaviour SHALL be identical either way.

Verification
REQ-038 Defaults; 2000 pixels h=0, s=200, v=200, then vsync rise -> color_o=1, max_count_o=2000, pulse at NUM_HUE_BINS+4 = 10 cycles.
REQ-039 Frame of 1500 pixels h=120 plus 1500 pixels h=240, both at s=200 v=200 -> tie; color_o=3, max_count_o=1500.
REQ-040 Frame of 500 pixels h=180, s=200 v=200 -> color_o=7, max_count_o=500.
REQ-041 Frame of 3000 pixels s=10 -> color_o=0; then hsv_de pulsed during SCAN -> drop_o=1, counts unchanged.
REQ-042 CNT_WIDTH=4; 20 pixels h=60, s=200 v=200 -> max_count_o=15 (saturated), color_o=7.
REQ-043 sys_rst asserted for 1 cycle mid-SCAN -> color_o=7, no pulse; the next vsync rise gives no report, the one after does.
